// File: rtl/fifo_pkg.sv
// Shared constants, sizing helpers and status record for the synchronous FIFO family.
package fifo_pkg;

  localparam int DATA_WIDTH    = 16;
  localparam int DEFAULT_DEPTH = 8;

  // Occupancy spans 0..depth inclusive, hence depth+1 states.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_if.sv
// Producer/consumer bundle for param_sync_fifo with a read-only status view.
interface fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic clk,
  input logic rst_n
);
  logic                        clr;
  logic                        wr_en;
  logic [WIDTH-1:0]            wr_data;
  logic                        rd_en;
  logic [WIDTH-1:0]            rd_data;
  logic                        rd_valid;
  logic                        full;
  logic                        empty;
  logic                        almost_full;
  logic                        almost_empty;
  logic [cnt_width(DEPTH)-1:0] count;
  logic                        overflow;
  logic                        underflow;

  modport producer (input clk, rst_n, full, almost_full, overflow,
                    output clr, wr_en, wr_data);
  modport consumer (input clk, rst_n, rd_data, rd_valid, empty, almost_empty, underflow,
                    output rd_en);
  modport status   (input clk, rst_n, full, empty, almost_full, almost_empty,
                    count, overflow, underflow);
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Wrap-at-DEPTH pointer pair, occupancy counter, request acceptance and status decode.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int PW        = ptr_width(DEPTH),
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic          wr_acc,
  output logic          rd_acc,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [CW-1:0] count,
  output fifo_status_t  status
);

  if (DEPTH < 2 || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_param
    $error("fifo_ptr_ctrl: illegal DEPTH/threshold combination");
  end

  logic ovf_q, udf_q;
  logic full, empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // clr swallows both requests so neither pointers nor storage move that cycle.
  assign rd_acc = rd_en && !empty && !clr;
  assign wr_acc = wr_en && (!full || rd_acc) && !clr;

  always_comb begin
    status              = '0;
    status.full         = full;
    status.empty        = empty;
    status.almost_full  = (int'(count) >= AF_THRESH);
    status.almost_empty = (int'(count) <= AE_THRESH);
    status.overflow     = ovf_q;
    status.underflow    = udf_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_acc)      count <= count + CW'(1);
      else if (rd_acc && !wr_acc) count <= count - CW'(1);
      if (wr_en && !wr_acc) ovf_q <= 1'b1;
      if (rd_en && !rd_acc) udf_q <= 1'b1;
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO: storage array plus registered or fall-through read path around fifo_ptr_ctrl.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter  int WIDTH     = DATA_WIDTH,
  parameter  int DEPTH     = DEFAULT_DEPTH,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  parameter  int FWFT      = 0,
  localparam int CW        = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_acc, rd_acc;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  fifo_status_t     st;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .wr_acc (wr_acc),
    .rd_acc (rd_acc),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .count  (count),
    .status (st)
  );

  assign full         = st.full;
  assign empty        = st.empty;
  assign almost_full  = st.almost_full;
  assign almost_empty = st.almost_empty;
  assign overflow     = st.overflow;
  assign underflow    = st.underflow;

  // Storage is left unreset; the pointers alone define what is live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    // Head word is presented as soon as it lands; rd_en only pops it.
    assign rd_data  = st.empty ? '0 : mem[rd_ptr];
    assign rd_valid = !st.empty;
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else if (clr) begin
        rd_data  <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= rd_acc;
        if (rd_acc) rd_data <= mem[rd_ptr];
      end
    end
  end

  a_full_and_empty: assert property (@(posedge clk) disable iff (!rst_n)
    !(full && empty));
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CW'(DEPTH));
  a_no_write_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(wr_acc && full && !rd_acc));
  a_post_reset: assert property (@(posedge clk)
    $rose(rst_n) |-> (empty && !full && rd_data == '0));

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: registered-read table, fall-through, non-power-of-two wrap, clr and async reset.
module tb_param_sync_fifo;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT0: WIDTH 16, DEPTH 8, registered read, driven through the interface bundle
  fifo_if #(.WIDTH(16), .DEPTH(8)) f0 (.clk(clk), .rst_n(rst_n));

  param_sync_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(f0.clr), .wr_en(f0.wr_en), .wr_data(f0.wr_data),
    .rd_en(f0.rd_en), .rd_data(f0.rd_data), .rd_valid(f0.rd_valid), .full(f0.full),
    .empty(f0.empty), .almost_full(f0.almost_full), .almost_empty(f0.almost_empty),
    .count(f0.count), .overflow(f0.overflow), .underflow(f0.underflow)
  );

  // DUT1: DEPTH 4, first-word-fall-through
  logic c1, w1, r1, v1, fu1, em1, af1, ae1, ov1, un1;
  logic [15:0] wd1, rd1;
  logic [2:0]  cnt1;
  param_sync_fifo #(.WIDTH(16), .DEPTH(4), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(c1), .wr_en(w1), .wr_data(wd1), .rd_en(r1),
    .rd_data(rd1), .rd_valid(v1), .full(fu1), .empty(em1), .almost_full(af1),
    .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1)
  );

  // DUT2: DEPTH 6 (non power of two), registered read
  logic c2, w2, r2, v2, fu2, em2, af2, ae2, ov2, un2;
  logic [15:0] wd2, rd2;
  logic [2:0]  cnt2;
  param_sync_fifo #(.WIDTH(16), .DEPTH(6), .FWFT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .clr(c2), .wr_en(w2), .wr_data(wd2), .rd_en(r2),
    .rd_data(rd2), .rd_valid(v2), .full(fu2), .empty(em2), .almost_full(af2),
    .almost_empty(ae2), .count(cnt2), .overflow(ov2), .underflow(un2)
  );

  typedef struct {
    logic        wr, rd, cl;
    logic [15:0] wd;
    logic [3:0]  cnt;
    logic        vld;
    logic [15:0] rdd;
    logic        ovf, udf;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic wr, input logic rd, input logic cl, input logic [15:0] wd,
                     input int cnt, input logic vld, input logic [15:0] rdd,
                     input logic ovf, input logic udf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.cl = cl; v.wd = wd; v.cnt = 4'(cnt);
    v.vld = vld; v.rdd = rdd; v.ovf = ovf; v.udf = udf;
    vq.push_back(v);
  endtask

  // Expected DUT0 observation; flags decoded from count with DEPTH 8, AF 6, AE 2.
  function automatic logic [63:0] exp0(input vec_t v);
    fifo_status_t s;
    s.full         = (v.cnt == 4'd8);
    s.empty        = (v.cnt == 4'd0);
    s.almost_full  = (v.cnt >= 4'd6);
    s.almost_empty = (v.cnt <= 4'd2);
    s.overflow     = v.ovf;
    s.underflow    = v.udf;
    return 64'({v.cnt, v.vld, v.rdd, s});
  endfunction

  function automatic logic [63:0] act0();
    fifo_status_t s;
    s = '{f0.full, f0.empty, f0.almost_full, f0.almost_empty, f0.overflow, f0.underflow};
    return 64'({f0.count, f0.rd_valid, f0.rd_data, s});
  endfunction

  initial begin
    f0.clr = 0; f0.wr_en = 0; f0.rd_en = 0; f0.wr_data = '0;
    c1 = 0; w1 = 0; r1 = 0; wd1 = '0;
    c2 = 0; w2 = 0; r2 = 0; wd2 = '0;

    // Registered-read table: fill/drain, underflow, overflow, full R+W, clr with write
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 16'(k), k, 0, 16'h0, 0, 0);
    for (int j = 1; j <= 8; j++) add(0, 1, 0, 16'h0, 8 - j, 1, 16'(j), 0, 0);
    add(0, 0, 0, 16'h0, 0, 0, 16'h0008, 0, 0);
    add(0, 1, 0, 16'h0, 0, 0, 16'h0008, 0, 1);
    add(1, 1, 0, 16'h00AA, 1, 0, 16'h0008, 0, 1);
    add(0, 1, 0, 16'h0, 0, 1, 16'h00AA, 0, 1);
    add(0, 0, 1, 16'h0, 0, 0, 16'h0, 0, 0);
    for (int k = 1; k <= 8; k++) add(1, 0, 0, 16'(k), k, 0, 16'h0, 0, 0);
    add(1, 0, 0, 16'hDEAD, 8, 0, 16'h0, 1, 0);
    add(1, 1, 0, 16'hBEEF, 8, 1, 16'h0001, 1, 0);
    for (int i = 1; i <= 8; i++)
      add(0, 1, 0, 16'h0, 8 - i, 1, (i < 8) ? 16'(i + 1) : 16'hBEEF, 1, 0);
    for (int k = 0; k < 5; k++) add(1, 0, 0, 16'(16'h50 + k), k + 1, 0, 16'hBEEF, 1, 0);
    add(1, 0, 1, 16'h0099, 0, 0, 16'h0, 0, 0);
    add(0, 1, 0, 16'h0, 0, 0, 16'h0, 0, 1);

    #12;
    chk("reset0", act0(), 64'({4'd0, 1'b0, 16'h0, 6'b010100}));
    chk("reset1", 64'({cnt1, v1, rd1, em1, fu1}), 64'({3'd0, 1'b0, 16'h0, 1'b1, 1'b0}));
    chk("reset2", 64'({cnt2, v2, rd2, em2, fu2, ae2}), 64'({3'd0, 1'b0, 16'h0, 3'b101}));
    rst_n = 1'b1;
    step();

    foreach (vq[i]) begin
      f0.wr_en = vq[i].wr; f0.rd_en = vq[i].rd; f0.clr = vq[i].cl; f0.wr_data = vq[i].wd;
      step();
      chk($sformatf("vec%0d", i), act0(), exp0(vq[i]));
    end
    f0.wr_en = 0; f0.rd_en = 0; f0.clr = 0;

    // Fall-through: word appears without rd_en, rd_en pops it
    w1 = 1; wd1 = 16'h1234; step();
    chk("fwft_first", 64'({cnt1, v1, rd1, em1}), 64'({3'd1, 1'b1, 16'h1234, 1'b0}));
    w1 = 0; step();
    chk("fwft_hold", 64'({cnt1, v1, rd1, em1}), 64'({3'd1, 1'b1, 16'h1234, 1'b0}));
    w1 = 1; wd1 = 16'h5678; step();
    chk("fwft_head", 64'({cnt1, v1, rd1, af1}), 64'({3'd2, 1'b1, 16'h1234, 1'b1}));
    w1 = 0; r1 = 1; step();
    chk("fwft_pop1", 64'({cnt1, v1, rd1, em1}), 64'({3'd1, 1'b1, 16'h5678, 1'b0}));
    step();
    chk("fwft_pop2", 64'({cnt1, v1, rd1, em1}), 64'({3'd0, 1'b0, 16'h0, 1'b1}));
    step();
    r1 = 0;
    chk("fwft_udf", 64'({cnt1, v1, un1, ov1}), 64'({3'd0, 1'b0, 1'b1, 1'b0}));

    // DEPTH 6 wrap: 3-deep preload, then 20 simultaneous write/read pairs
    for (int k = 0; k < 3; k++) begin w2 = 1; wd2 = 16'(k); step(); end
    for (int k = 0; k < 20; k++) begin
      w2 = 1; r2 = 1; wd2 = 16'(k + 3); step();
      chk($sformatf("wrap%0d", k), 64'({cnt2, v2, rd2, ov2, un2, fu2}),
          64'({3'd3, 1'b1, 16'(k), 3'b000}));
    end
    w2 = 0; r2 = 1;
    for (int k = 20; k < 23; k++) begin
      step();
      chk($sformatf("drain%0d", k), 64'({cnt2, rd2}), 64'({3'(22 - k), 16'(k)}));
    end
    r2 = 0; w2 = 1;
    for (int i = 0; i < 6; i++) begin wd2 = 16'(16'h100 + i); step(); end
    w2 = 0;
    chk("d6_full", 64'({cnt2, fu2, af2, em2, ov2, un2}), 64'({3'd6, 5'b11000}));
    r2 = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("d6_rd%0d", i), 64'({v2, rd2}), 64'({1'b1, 16'(16'h100 + i)}));
    end
    r2 = 0; step();
    chk("d6_empty", 64'({cnt2, em2, ov2, un2}), 64'({3'd0, 3'b100}));

    // Async reset mid-burst on DUT0 (underflow is set from the table)
    for (int k = 0; k < 3; k++) begin f0.wr_en = 1; f0.wr_data = 16'(16'h61 + k); step(); end
    f0.wr_en = 0; f0.rd_en = 1; step();
    f0.rd_en = 0;
    chk("pre_rst", act0(), 64'({4'd2, 1'b1, 16'h0061, 6'b000101}));
    #3 rst_n = 1'b0;
    #1 chk("async_rst", act0(), 64'({4'd0, 1'b0, 16'h0, 6'b010100}));
    #1 rst_n = 1'b1;
    step();
    f0.wr_en = 1; f0.wr_data = 16'h0077; step();
    f0.wr_data = 16'h0078; step();
    f0.wr_en = 0; f0.rd_en = 1; step();
    f0.rd_en = 0;
    chk("post_rst_rd", act0(), 64'({4'd1, 1'b1, 16'h0077, 6'b000100}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Single-clock synchronous FIFO, the parametrised successor to the fixed-width fifo_if protocol block.
- Data width, depth, almost-full/almost-empty thresholds and read mode (registered or first-word-fall-through) are set by parameters.
- Adds an occupancy count, a synchronous flush, and sticky overflow/underflow error flags.
- Sits between any producer/consumer pair in the datapath and replaces ad-hoc fixed-size buffers.

Parameters:
- WIDTH, default fifo_pkg::DATA_WIDTH: data bits per entry; must be >= 1.
- DEPTH, default 8: number of entries; must be >= 2; not required to be a power of two.
- AF_THRESH, default DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, default 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, default 0: 0 selects registered read, 1 selects first-word-fall-through.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- clr  in  1  synchronous flush; empties the FIFO and clears the error flags.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data holds a freshly popped word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH+1)  current occupancy.
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- Reset (rst_n=0, asynchronous): pointers=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Status outputs follow from count: empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), which is 0 for any legal AF_THRESH. Memory contents need not be reset.
- Acceptance, evaluated combinationally on the current state:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc).
  - A write into a full FIFO is therefore accepted when a read is accepted in the same cycle.
- Rejection flags:
  - wr_en && !wr_acc sets overflow on the next edge.
  - rd_en && !rd_acc sets underflow on the next edge.
  - Both flags stay set until clr or reset.
- Pointers: wr_ptr advances on wr_acc, rd_ptr advances on rd_acc. Each wraps DEPTH-1 -> 0 by explicit compare, not modulo-2^n.
- Count update:
  - count += 1 on wr_acc && !rd_acc.
  - count -= 1 on rd_acc && !wr_acc.
  - Unchanged when both or neither are accepted.
  - full, empty, almost_full and almost_empty are decoded from count and valid in the same cycle as count.
- FWFT=0 (registered read):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid <= 1 at the next edge; read latency is 1 cycle.
  - Otherwise rd_valid <= 0 and rd_data holds its last value.
- FWFT=1 (first-word-fall-through):
  - rd_data = mem[rd_ptr] combinationally whenever !empty, and 0 when empty.
  - rd_valid = !empty.
  - rd_en acknowledges (pops) the presented word.
  - A word written into an empty FIFO is visible on rd_data the cycle after the write.
- Simultaneous read and write:
  - Empty FIFO: the read is rejected (underflow set), the write is accepted, count becomes 1. There is no write-to-read bypass.
  - Full FIFO: both accepted, count stays DEPTH, the oldest word is returned.
- clr (synchronous, highest priority after reset):
  - Next state equals reset state; wr_en and rd_en in the same cycle are ignored.
  - Neither overflow nor underflow is set by that cycle's requests.
- Reset asserted mid-burst: all state is discarded immediately. The first accepted write after release is read back first.
- Assertions (bound in the block):
  - !(full && empty).
  - count <= DEPTH.
  - No accepted write while full && !rd_acc.
  - Immediately after reset, empty=1, full=0, rd_data=0.

Decomposition:
- fifo_pkg gains:
  - DEFAULT_DEPTH constant.
  - Function cnt_width(depth) returning $clog2(depth+1).
  - typedef fifo_status_t: packed struct {full, empty, almost_full, almost_empty, overflow, underflow}, for bench monitors and status registers.
- One sub-module: fifo_ptr_ctrl.
  - Contains the wrap-at-DEPTH pointer pair, the count register, acceptance logic and flag decode.
  - The top level holds the storage array and the read-data path for both FWFT modes.
- fifo_if is extended with the new status signals and a status modport for the bench.

Test Plan:
1. WIDTH=16, DEPTH=8, FWFT=0. Write 0x0001..0x0008 on 8 consecutive cycles -> full=1 and count=8 after the 8th edge; almost_full=1 from count 6. Read 8 cycles -> rd_data 0x0001..0x0008, each with a 1-cycle rd_valid pulse, then empty=1.
2. Full FIFO, wr_en=1 alone with data 0xDEAD -> overflow=1, count stays 8, 0xDEAD never read. Then wr_en=rd_en=1 with data 0xBEEF -> count stays 8, rd_data=0x0001, 0xBEEF read last.
3. Empty FIFO, rd_en=1 -> underflow=1, rd_valid=0, count=0. Same-cycle wr_en=1 with data 0x00AA -> count=1, 0x00AA is the next word read.
4. FWFT=1, write 0x1234 into an empty FIFO -> next cycle rd_valid=1 and rd_data=0x1234 with no rd_en. Pulse rd_en -> empty=1, rd_data=0.
5. Pointer wrap, DEPTH=6: 20 interleaved write/read pairs with an incrementing pattern -> data in order, count never exceeds 6, no flags set.
6. count=5 with overflow=1. Assert clr with wr_en=1 -> next cycle count=0, empty=1, overflow=0, write dropped. Repeat with rst_n pulsed low mid-cycle -> outputs reset asynchronously before the next edge.
